// File: rtl/lt24_arb_pkg.sv
// Shared types and constants for the LT24 pixel write-port arbiter.
// Holds the owner-state encoding, requester indices and display geometry.
package lt24_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_MAZE   = 0;
  localparam int unsigned REQ_SPRITE = 1;

  localparam int unsigned WIDTH  = 240;
  localparam int unsigned HEIGHT = 320;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned PIX_W = 16;

  // RGB565 layout: {R[4:0], G[5:0], B[4:0]}
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_R_W   = 5;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_G_W   = 6;
  localparam int unsigned RGB_B_LSB = 0;
  localparam int unsigned RGB_B_W   = 5;

  function automatic arb_state_e own_state(input logic req);
    return req ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/lt24_pixel_holding_reg.sv
// One-deep registered pixel stage: loads on i_load, holds while stalled,
// and empties when the display signals ready without a new load.
module lt24_pixel_holding_reg
  import lt24_arb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [X_W-1:0]   i_x,
  input  logic [Y_W-1:0]   i_y,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [X_W-1:0]   o_x,
  output logic [Y_W-1:0]   o_y,
  output logic [PIX_W-1:0] o_data
);

  logic             r_valid;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [PIX_W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_x     <= i_x;
      r_y     <= i_y;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_data  = r_data;

endmodule

// File: rtl/lt24_pixel_arbiter.sv
// Round-robin, burst-granular arbiter between the maze and sprite renderers
// for the LT24 pixel write port, with burst cap and idle-release timeout.
module lt24_pixel_arbiter
  import lt24_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX    = 16,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                 clock,
  input  logic                 globalReset,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_last,
  input  logic [2*X_W-1:0]     req_x,
  input  logic [2*Y_W-1:0]     req_y,
  input  logic [2*PIX_W-1:0]   req_data,
  output logic [1:0]           req_ready,
  output logic [1:0]           grant,
  output logic [X_W-1:0]       xAddr,
  output logic [Y_W-1:0]       yAddr,
  output logic [PIX_W-1:0]     pixelData,
  output logic                 pixelWrite,
  input  logic                 pixelReady
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BurstMax = BW'(BURST_MAX);
  localparam logic [IW-1:0] IdleMax  = IW'(IDLE_TIMEOUT);

  arb_state_e    r_state, w_state_next;
  logic          r_last, w_last_next;
  logic [BW-1:0] r_burst_cnt, w_burst_next, w_burst_inc;
  logic [IW-1:0] r_idle_cnt, w_idle_next, w_idle_inc;

  logic             w_owner;
  logic             w_other;
  logic             w_pick;
  logic             w_out_free;
  logic             w_xfer;
  logic             w_release;
  logic [X_W-1:0]   w_sel_x;
  logic [Y_W-1:0]   w_sel_y;
  logic [PIX_W-1:0] w_sel_data;

  assign w_owner    = (r_state == StOwn1);
  assign w_other    = ~w_owner;
  assign w_out_free = !pixelWrite || pixelReady;
  assign grant      = {r_state == StOwn1, r_state == StOwn0};
  assign req_ready  = grant & {2{w_out_free}};
  assign w_xfer     = |(req_valid & req_ready);

  // On a tie the requester that did not own the port last time wins.
  assign w_pick = (req_valid == 2'b11) ? ~r_last : req_valid[1];

  assign w_sel_x    = w_owner ? req_x[REQ_SPRITE*X_W +: X_W] : req_x[REQ_MAZE*X_W +: X_W];
  assign w_sel_y    = w_owner ? req_y[REQ_SPRITE*Y_W +: Y_W] : req_y[REQ_MAZE*Y_W +: Y_W];
  assign w_sel_data = w_owner ? req_data[REQ_SPRITE*PIX_W +: PIX_W]
                              : req_data[REQ_MAZE*PIX_W +: PIX_W];

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_burst_next = r_burst_cnt;
    w_idle_next  = r_idle_cnt;
    w_burst_inc  = r_burst_cnt;
    w_idle_inc   = r_idle_cnt;
    w_release    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid != 2'b00) begin
          w_state_next = own_state(w_pick);
          w_last_next  = w_pick;
          w_burst_next = '0;
          w_idle_next  = '0;
        end
      end
      StOwn0, StOwn1: begin
        w_burst_inc = (w_xfer && (r_burst_cnt != BurstMax)) ? r_burst_cnt + 1'b1 : r_burst_cnt;
        w_idle_inc  = req_valid[w_owner] ? '0 : r_idle_cnt + 1'b1;
        w_release   = (w_xfer && req_last[w_owner])
                   || (w_xfer && (w_burst_inc == BurstMax) && req_valid[w_other])
                   || (w_idle_inc == IdleMax);
        w_burst_next = w_burst_inc;
        w_idle_next  = w_idle_inc;
        if (w_release) begin
          w_burst_next = '0;
          w_idle_next  = '0;
          if (req_valid[w_other]) begin
            w_state_next = own_state(w_other);
            w_last_next  = w_other;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge globalReset) begin
    if (!globalReset) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_last      <= w_last_next;
      r_burst_cnt <= w_burst_next;
      r_idle_cnt  <= w_idle_next;
    end
  end

  lt24_pixel_holding_reg u_hold (
    .i_clk   (clock),
    .i_rst_n (globalReset),
    .i_load  (w_xfer),
    .i_x     (w_sel_x),
    .i_y     (w_sel_y),
    .i_data  (w_sel_data),
    .i_ready (pixelReady),
    .o_valid (pixelWrite),
    .o_x     (xAddr),
    .o_y     (yAddr),
    .o_data  (pixelData)
  );

endmodule
